// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode and redirect signals of the fetch front end.
interface fetch_unit_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 32,
   parameter int IMM_W   = 12,
   parameter int DEPTH   = 4
);
   logic                       imem_req;
   logic [ADDR_W-1:0]          imem_addr;
   logic                       imem_valid;
   logic [INSTR_W-1:0]         imem_rdata;
   logic                       inst_valid;
   logic [INSTR_W-1:0]         inst_data;
   logic [ADDR_W-1:0]          inst_pc;
   logic                       inst_ready;
   logic                       redirect_valid;
   logic [1:0]                 redirect_mode;
   logic [ADDR_W-1:0]          redirect_base;
   logic [IMM_W-1:0]           redirect_imm;
   logic [$clog2(DEPTH):0]     fifo_count;

   modport master (
      output imem_req, imem_addr, inst_valid, inst_data, inst_pc, fifo_count,
      input  imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_mode,
             redirect_base, redirect_imm
   );

   modport slave (
      input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, fifo_count,
      output imem_valid, imem_rdata, inst_ready, redirect_valid, redirect_mode,
             redirect_base, redirect_imm
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues one outstanding imem fetch at a time and buffers words in a prefetch FIFO.
module fetch_unit #(
   parameter int ADDR_W   = 16,
   parameter int INSTR_W  = 32,
   parameter int IMM_W    = 12,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 1
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] READY = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] DROP  = 2'd2;

   logic [1:0]         state;
   logic               live;
   logic [ADDR_W-1:0]  fetch_pc;
   logic [ADDR_W-1:0]  req_addr;
   logic [ADDR_W-1:0]  target;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic [ADDR_W-1:0]  pc_q [DEPTH];
   logic [INSTR_W-1:0] data_q [DEPTH];
   logic               redir;
   logic               has;
   logic               issue;
   logic               push;
   logic               pop;

   // live keeps imem_req low until the first edge after reset releases
   assign redir = bus.redirect_valid;
   assign has   = count != '0;
   assign issue = live && state == READY && !redir && !count[AW];
   assign push  = state == WAIT && bus.imem_valid && !redir;
   assign pop   = has && bus.inst_ready && !redir;

   always_comb
      target = bus.redirect_mode == 2'b01 ? bus.redirect_base + {{(ADDR_W-IMM_W){bus.redirect_imm[IMM_W-1]}}, bus.redirect_imm} :
               bus.redirect_mode == 2'b10 ? {bus.redirect_base[ADDR_W-1:IMM_W], bus.redirect_imm} :
               bus.redirect_base;

   assign bus.imem_req   = issue;
   assign bus.imem_addr  = issue ? fetch_pc : '0;
   assign bus.inst_valid = has;
   assign bus.inst_data  = has ? data_q[rd_ptr] : '0;
   assign bus.inst_pc    = has ? pc_q[rd_ptr] : '0;
   assign bus.fifo_count = count;

   // any response arriving outside READY ends the outstanding request, pushed or not
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state    <= READY;
         live     <= 1'b0;
         fetch_pc <= ADDR_W'(RESET_PC);
         req_addr <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         live  <= 1'b1;
         state <= issue ? WAIT :
                  (state != READY && bus.imem_valid) ? READY :
                  (state == WAIT && redir) ? DROP : state;
         if (issue) req_addr <= fetch_pc;
         if (redir) begin
            fetch_pc <= target;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
         end else begin
            if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end

   always_ff @(posedge clk)
      if (push) begin
         pc_q[wr_ptr]   <= req_addr;
         data_q[wr_ptr] <= bus.imem_rdata;
      end
endmodule
